block_memory: RTL and testbench
===============================

BLOCK_MEMORY -- requirements
Module: block_memory

Interface
REQ-001 Parameter LATENCY, default 4: cycles from request acceptance to response pulse; legal range 1..15.
REQ-002 Parameter ADDR_BITS, default 8: number of low block-address bits that index storage; 2**ADDR_BITS blocks.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_write  input  1  1 = block writeback, 0 = block fill (read).
REQ-007 req_addr  input  28  block address {tag[25:0], index[1:0]}.
REQ-008 req_data  input  128  writeback block; word 0 in bits [31:0], word 3 in [127:96].
REQ-009 req_ready  output  1  high only when able to accept a request.
REQ-010 resp_valid  output  1  one-cycle completion pulse; drives the cache's block-update strobe directly.
REQ-011 resp_write  output  1  type of the completing request.
REQ-012 resp_data  output  128  fill block for reads; echo of written block for writes.

Function
REQ-013 A request SHALL be accepted at the rising edge where req_valid && req_ready; req_write, req_addr and req_data SHALL be captured at that edge, and later input changes SHALL have no effect.
REQ-014 req_valid while req_ready is low SHALL be ignored, with no state change.
REQ-015 FSM states SHALL be IDLE, BUSY and RESP.
  - IDLE: req_ready = 1.
  - BUSY: req_ready = 0; holds LATENCY-1 cycles; skipped when LATENCY = 1.
  - RESP: req_ready = 0; resp_valid = 1 for exactly one cycle; then IDLE.
REQ-016 For acceptance at edge N, resp_valid SHALL be high between edges N+LATENCY and N+LATENCY+1.
  - The next acceptance SHALL occur no earlier than edge N+LATENCY+1.
  - At most one request SHALL ever be outstanding.
REQ-017 Storage SHALL be indexed by req_addr[ADDR_BITS-1:0]; upper address bits SHALL be ignored, so addresses alias modulo 2**ADDR_BITS.
REQ-018 A write SHALL commit its captured block to storage at edge N+LATENCY, the same edge resp_valid rises, never earlier.
REQ-019 For a read, resp_data SHALL be loaded at edge N+LATENCY with the stored block.
  - A write completing at or before that edge SHALL be visible to the read.
REQ-020 For a write, resp_data SHALL be loaded with the captured req_data.
REQ-021 resp_write SHALL be loaded with the captured req_write at the same edge as resp_data.
REQ-022 resp_data and resp_write SHALL hold their last loaded values until the next response.
REQ-023 The latency counter SHALL be sized for LATENCY-1 and SHALL never wrap.
REQ-024 req_valid asserted in the RESP cycle SHALL NOT be accepted; it SHALL be accepted on the following IDLE cycle if still asserted.

Reset
REQ-025 On reset low, the following SHALL take effect immediately, without waiting for a clock edge:
  - state = IDLE, counter = 0;
  - req_ready = 1;
  - resp_valid = 0, resp_write = 0, resp_data = 0.
REQ-026 Storage contents SHALL NOT be cleared by reset; storage SHALL power up to all zero.
REQ-027 On reset mid-operation, the pending request SHALL be dropped; an uncommitted write SHALL leave storage unchanged.
REQ-028 Reset deassertion SHALL take effect at the next rising clock edge only; the first acceptance SHALL be possible at that edge.

Structure
REQ-029 A shared package SHALL hold:
  - block width (128) and block-address width (28);
  - the FSM state enum {IDLE, BUSY, RESP};
  - the request and response field widths.
REQ-030 Storage SHALL be a sub-module block_memory_array: one write port and one read port, registered read, no reset.
REQ-031 FSM, counter and capture registers SHALL reside in block_memory.

Verification
REQ-032 Read latency: after reset, LATENCY=4, read addr 0x0000003 accepted at edge 10 -> resp_valid high only in cycle 14–15, resp_data = 0, resp_write = 0.
REQ-033 Write then read:
  - write addr 0x0000005, data 0x0123...CDEF (128b) -> resp_write = 1, data echoed;
  - read same addr -> returns identical 128-bit block.
REQ-034 Aliasing: ADDR_BITS=8, write addr 0x0000105 data X, then read 0x0000005 -> returns X.
REQ-035 Back-pressure: hold req_valid=1 with alternating addresses; req_ready low from accept to end of RESP; exactly one response per LATENCY+1 cycles; inputs changed mid-flight are not reflected.
REQ-036 Reset mid-write: write addr 2 data 0xFF..FF, assert reset at accept+2 -> no resp_valid, req_ready = 1 immediately; later read addr 2 returns the prior contents.
REQ-037 LATENCY=1: read accepted at edge N -> resp_valid high between edges N+1 and N+2; next accept at edge N+2.

Source files
------------

// File: rtl/block_memory_pkg.sv
// -----------------------------------------------------------------------------
// block_memory_pkg
//   Shared definitions for the block memory slice. These are the block and
//   block-address widths, the request/response field widths, the FSM state
//   encoding and a helper that sizes the latency counter.
// -----------------------------------------------------------------------------
package block_memory_pkg;

  // Block geometry: four 32-bit words per block, word 0 in the low bits.
  localparam int BLOCK_W         = 128;
  localparam int WORD_W          = 32;
  localparam int WORDS_PER_BLOCK = BLOCK_W / WORD_W;

  // Block address: {tag[25:0], index[1:0]}.
  localparam int BADDR_W = 28;
  localparam int TAG_W   = 26;
  localparam int INDEX_W = 2;

  // Request fields: write flag, block address, writeback block.
  localparam int REQ_WRITE_W = 1;
  localparam int REQ_ADDR_W  = BADDR_W;
  localparam int REQ_DATA_W  = BLOCK_W;
  localparam int REQ_W       = REQ_WRITE_W + REQ_ADDR_W + REQ_DATA_W;

  // Response fields: write flag, fill/echo block.
  localparam int RESP_WRITE_W = 1;
  localparam int RESP_DATA_W  = BLOCK_W;
  localparam int RESP_W       = RESP_WRITE_W + RESP_DATA_W;

  // Controller states, with fixed encodings so traces stay comparable
  // across revisions.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  // Width of a counter that must hold LATENCY-1. It never drops below
  // one bit, so the LATENCY=1 build still has a legal (unused) counter.
  function automatic int cnt_width(input int latency);
    int w;
    w = (latency > 1) ? $clog2(latency) : 1;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/block_memory_array.sv
// -----------------------------------------------------------------------------
// block_memory_array
//   Block storage: 2**ADDR_BITS entries of BLOCK_W bits. It has one write
//   port and one read port, and both act on the rising clock edge. The read
//   is registered, so rd_data shows the entry addressed by rd_addr at the
//   previous edge. A write on that same edge is not visible until the
//   following read.
//   There is no reset. Contents power up to zero and survive reset.
//
// Ports
//   clock    in   rising-edge clock
//   wr_en    in   commit wr_data to wr_addr at this edge
//   wr_addr  in   ADDR_BITS write index
//   wr_data  in   BLOCK_W write block
//   rd_addr  in   ADDR_BITS read index (sampled every edge)
//   rd_data  out  BLOCK_W registered read block
// -----------------------------------------------------------------------------
module block_memory_array
  import block_memory_pkg::*;
#(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clock,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [BLOCK_W-1:0]   wr_data,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [BLOCK_W-1:0]   rd_data
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  // Declaration initialiser gives the all-zero power-up image.
  logic [BLOCK_W-1:0] mem [DEPTH] = '{default: '0};

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/block_memory.sv
// -----------------------------------------------------------------------------
// block_memory
//   Single-outstanding block memory behind a cache. It accepts one fill or
//   writeback request, waits LATENCY cycles, then returns a one-cycle
//   completion pulse with the fill block (read) or the echoed block (write).
//
//   Timeline for acceptance at edge N:
//     N              -> BUSY (or straight to RESP when LATENCY = 1)
//     N+1..N+L-1     BUSY counts L-1 cycles
//     N+L-1          -> RESP; storage read is issued on this edge
//     N+L            write commits, resp_* load, resp_valid rises, -> IDLE
//     N+L+1          earliest next acceptance (req_ready high since N+L)
//
// Ports
//   clock       in   rising-edge clock
//   reset       in   asynchronous active-low reset
//   req_valid   in   request present
//   req_write   in   1 = writeback, 0 = fill
//   req_addr    in   28-bit block address; low ADDR_BITS index storage
//   req_data    in   128-bit writeback block
//   req_ready   out  high only in IDLE
//   resp_valid  out  one-cycle completion pulse
//   resp_write  out  type of the completing request
//   resp_data   out  fill block or echoed writeback block
// -----------------------------------------------------------------------------
module block_memory
  import block_memory_pkg::*;
#(
  parameter int LATENCY   = 4,
  parameter int ADDR_BITS = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req_valid,
  input  logic               req_write,
  input  logic [BADDR_W-1:0] req_addr,
  input  logic [BLOCK_W-1:0] req_data,
  output logic               req_ready,
  output logic               resp_valid,
  output logic               resp_write,
  output logic [BLOCK_W-1:0] resp_data
);

  localparam int CNT_W = cnt_width(LATENCY);
  // Last BUSY count. The counter runs 0..LATENCY-2 and is then cleared, so
  // it never wraps.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((LATENCY > 1) ? (LATENCY - 2) : 0);

  state_e               state_p0;
  logic [CNT_W-1:0]     cnt_p0;
  logic                 cap_write_p0;
  logic [ADDR_BITS-1:0] cap_idx_p0;
  logic [BLOCK_W-1:0]   cap_data_p0;
  logic [BLOCK_W-1:0]   rd_data_p1;

  logic                 accept;
  logic                 wr_en;
  logic [ADDR_BITS-1:0] rd_idx;

  // Upper block-address bits alias onto the same storage entry.
  generate
    if (ADDR_BITS < BADDR_W) begin : g_alias
      logic unused_upper_addr;
      assign unused_upper_addr = ^req_addr[BADDR_W-1:ADDR_BITS];
    end
  endgenerate

  assign req_ready = (state_p0 == IDLE);
  assign accept    = req_valid && req_ready;

  // The registered read must be launched on the edge that enters RESP. With
  // LATENCY = 1 that edge is the acceptance edge itself, so the index comes
  // straight from the request while idle. Otherwise it comes from the
  // capture register.
  assign rd_idx = (state_p0 == IDLE) ? req_addr[ADDR_BITS-1:0] : cap_idx_p0;

  // Writes commit only on the edge that leaves RESP. A reset during BUSY
  // therefore never disturbs storage.
  assign wr_en = (state_p0 == RESP) && cap_write_p0;

  // ---- stage p0: control FSM and latency counter ----
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_p0 <= IDLE;
      cnt_p0   <= '0;
    end else begin
      case (state_p0)
        IDLE: begin
          if (accept) begin
            state_p0 <= (LATENCY == 1) ? RESP : BUSY;
            cnt_p0   <= '0;
          end
        end
        BUSY: begin
          if (cnt_p0 == CNT_LAST) begin
            state_p0 <= RESP;
            cnt_p0   <= '0;
          end else begin
            cnt_p0 <= cnt_p0 + CNT_W'(1);
          end
        end
        RESP: begin
          state_p0 <= IDLE;
        end
        default: begin
          state_p0 <= IDLE;
          cnt_p0   <= '0;
        end
      endcase
    end
  end

  // ---- stage p0: request capture (data path, no reset) ----
  always_ff @(posedge clock) begin
    if (accept) begin
      cap_write_p0 <= req_write;
      cap_idx_p0   <= req_addr[ADDR_BITS-1:0];
      cap_data_p0  <= req_data;
    end
  end

  // ---- stage p1: storage, read data registered inside the array ----
  block_memory_array #(
    .ADDR_BITS (ADDR_BITS)
  ) u_array (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (cap_idx_p0),
    .wr_data (cap_data_p0),
    .rd_addr (rd_idx),
    .rd_data (rd_data_p1)
  );

  // ---- stage p2: response registers, loaded on the edge leaving RESP ----
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      resp_valid <= 1'b0;
      resp_write <= 1'b0;
      resp_data  <= '0;
    end else begin
      resp_valid <= (state_p0 == RESP);
      if (state_p0 == RESP) begin
        resp_write <= cap_write_p0;
        resp_data  <= cap_write_p0 ? cap_data_p0 : rd_data_p1;
      end
    end
  end

endmodule

// File: tb/tb_block_memory.sv
module tb_block_memory;

  logic clock = 1'b0;
  logic reset;

  // Index 0: LATENCY=4 instance, index 1: LATENCY=1 instance.
  logic         req_valid [2];
  logic         req_write [2];
  logic [27:0]  req_addr  [2];
  logic [127:0] req_data  [2];

  logic         req_ready0, resp_valid0, resp_write0;
  logic [127:0] resp_data0;
  logic         req_ready1, resp_valid1, resp_write1;
  logic [127:0] resp_data1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [127:0] model     [2][256];
  logic [127:0] last_data [2];
  int           lat       [2];

  always #5 clock = ~clock;

  block_memory #(.LATENCY(4), .ADDR_BITS(8)) dut_l4 (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid[0]),
    .req_write  (req_write[0]),
    .req_addr   (req_addr[0]),
    .req_data   (req_data[0]),
    .req_ready  (req_ready0),
    .resp_valid (resp_valid0),
    .resp_write (resp_write0),
    .resp_data  (resp_data0)
  );

  block_memory #(.LATENCY(1), .ADDR_BITS(8)) dut_l1 (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid[1]),
    .req_write  (req_write[1]),
    .req_addr   (req_addr[1]),
    .req_data   (req_data[1]),
    .req_ready  (req_ready1),
    .resp_valid (resp_valid1),
    .resp_write (resp_write1),
    .resp_data  (resp_data1)
  );

  function automatic logic ready_of(input int u);
    return (u == 0) ? req_ready0 : req_ready1;
  endfunction

  function automatic logic valid_of(input int u);
    return (u == 0) ? resp_valid0 : resp_valid1;
  endfunction

  function automatic logic rwrite_of(input int u);
    return (u == 0) ? resp_write0 : resp_write1;
  endfunction

  function automatic logic [127:0] rdata_of(input int u);
    return (u == 0) ? resp_data0 : resp_data1;
  endfunction

  function automatic logic [127:0] rnd_block();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one request from a negedge in an idle cycle and follow it to
  // completion. The response must appear exactly lat[u] edges after
  // acceptance. Inputs are scrambled while the request is in flight, with
  // req_valid held high.
  task automatic txn(input int u, input logic w, input logic [27:0] a, input logic [127:0] d);
    logic [127:0] exp;
    int idx;
    idx = int'(a) % 256;
    exp = w ? d : model[u][idx];
    chk($sformatf("u%0d ready_before_accept", u), ready_of(u), 1);
    req_valid[u] = 1'b1;
    req_write[u] = w;
    req_addr[u]  = a;
    req_data[u]  = d;
    @(posedge clock);
    #1;
    req_write[u] = 1'($urandom);
    req_addr[u]  = 28'($urandom);
    req_data[u]  = rnd_block();
    for (int j = 0; j <= lat[u]; j++) begin
      @(negedge clock);
      if (j < lat[u]) begin
        chk($sformatf("u%0d inflight_ready j%0d", u, j), ready_of(u), 0);
        chk($sformatf("u%0d inflight_valid j%0d", u, j), valid_of(u), 0);
      end else begin
        chk($sformatf("u%0d resp_ready a%0h", u, a), ready_of(u), 1);
        chk($sformatf("u%0d resp_valid a%0h", u, a), valid_of(u), 1);
        chk($sformatf("u%0d resp_write a%0h", u, a), rwrite_of(u), w);
        chk($sformatf("u%0d resp_data a%0h", u, a), rdata_of(u), exp);
      end
    end
    if (w) model[u][idx] = d;
    last_data[u] = exp;
    req_valid[u] = 1'b0;
  endtask

  task automatic idle(input int u, input int n);
    req_valid[u] = 1'b0;
    repeat (n) begin
      @(negedge clock);
      chk($sformatf("u%0d idle_valid", u), valid_of(u), 0);
      chk($sformatf("u%0d idle_ready", u), ready_of(u), 1);
      chk($sformatf("u%0d idle_hold_data", u), rdata_of(u), last_data[u]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (observed timeout, expected completion)");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] x;
    logic [27:0]  a;
    lat[0] = 4;
    lat[1] = 1;
    for (int u = 0; u < 2; u++) begin
      req_valid[u] = 1'b0;
      req_write[u] = 1'b0;
      req_addr[u]  = '0;
      req_data[u]  = '0;
      last_data[u] = '0;
      for (int i = 0; i < 256; i++) model[u][i] = '0;
    end

    // Asynchronous reset takes effect before any clock edge.
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("u%0d rst_ready", u), ready_of(u), 1);
      chk($sformatf("u%0d rst_valid", u), valid_of(u), 0);
      chk($sformatf("u%0d rst_write", u), rwrite_of(u), 0);
      chk($sformatf("u%0d rst_data", u), rdata_of(u), 0);
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // First acceptance on the first edge after release; power-up contents are zero.
    txn(0, 1'b0, 28'h0000003, rnd_block());
    txn(1, 1'b0, 28'h0000003, rnd_block());

    // Write then read back.
    txn(0, 1'b1, 28'h0000005, 128'h0123456789ABCDEF0123456789ABCDEF);
    txn(0, 1'b0, 28'h0000005, rnd_block());

    // Aliasing modulo 256.
    x = rnd_block();
    txn(0, 1'b1, 28'h0000105, x);
    txn(0, 1'b0, 28'h0000005, rnd_block());

    // Back-to-back with req_valid held, alternating addresses.
    for (int i = 0; i < 6; i++) begin
      txn(0, 1'($urandom), (i % 2 == 0) ? 28'h0000040 : 28'h0000141, rnd_block());
    end
    idle(0, 3);

    // Random traffic over a small index set with random upper bits.
    for (int i = 0; i < 24; i++) begin
      a = {20'($urandom), 4'h0, 4'($urandom)};
      txn(0, 1'($urandom_range(0, 1)), a, rnd_block());
      if ($urandom_range(0, 2) == 0) idle(0, 1);
    end

    // LATENCY=1 instance: random traffic, back-to-back.
    for (int i = 0; i < 12; i++) begin
      a = {20'($urandom), 5'h0, 3'($urandom)};
      txn(1, 1'($urandom_range(0, 1)), a, rnd_block());
    end
    idle(1, 2);

    // Reset during an in-flight write leaves storage untouched.
    txn(0, 1'b1, 28'h0000002, rnd_block());
    req_valid[0] = 1'b1;
    req_write[0] = 1'b1;
    req_addr[0]  = 28'h0000002;
    req_data[0]  = '1;
    @(posedge clock);
    #1 req_valid[0] = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    chk("midwrite_rst_ready", req_ready0, 1);
    chk("midwrite_rst_valid", resp_valid0, 0);
    chk("midwrite_rst_write", resp_write0, 0);
    chk("midwrite_rst_data", resp_data0, 0);
    last_data[0] = '0;
    last_data[1] = '0;
    @(negedge clock);
    reset = 1'b1;
    idle(0, 6);
    txn(0, 1'b0, 28'h0000002, rnd_block());
    idle(1, 1);
    txn(1, 1'b0, 28'h0000003, rnd_block());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
